// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
//
// Measures the high time and the rise-to-rise period of an asynchronous PWM
// input in clk cycles. pwm_in passes through a two-flop synchroniser and an
// edge detector. A four-state FSM counts cycles between qualifying edges. If
// no expected edge arrives within TIMEOUT cycles, the FSM reports a stuck
// level instead of a measurement.
//
// Optional feature: define PWM_CAPTURE_GLITCH_FILTER_EN to insert a
// three-sample glitch filter after the synchroniser. The filter ignores
// pulses shorter than 3 clk and adds 2 clk of edge latency.
//
// Parameters
//   TIMEOUT       cycles without an expected edge before a stuck-level result
//                 is reported (legal range 4..16'hFFFF)
// Ports
//   clk           sole clock, rising edge
//   reset         asynchronous, active-low reset
//   pwm_in        PWM waveform under measurement, asynchronous to clk
//   enable        measurement enable, synchronous to clk
//   high_count    high cycles of the last complete period
//   period_count  cycles of the last complete period, rise to rise
//   meas_valid    one-cycle pulse when high_count/period_count update
//   timeout       sticky stuck-level flag, cleared by the next real period
//   stuck_level   pwm level at the last timeout
// ---------------------------------------------------------------------------
module pwm_capture #(
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pwm_in,
  input  logic        enable,
  output logic [15:0] high_count,
  output logic [15:0] period_count,
  output logic        meas_valid,
  output logic        timeout,
  output logic        stuck_level
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] cnt_inc;
  logic [15:0] hi_lat;

  logic pwm_meta;
  logic pwm_s;
  logic pwm_lvl;   // level seen by the edge detector (filtered or not)
  logic pwm_d;
  logic rise;
  logic fall;
  logic edge_hit;  // the edge the current state is waiting for

  // NOTE: every flop here uses non-blocking assignment, so all registers
  // update together at the clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_meta <= 1'b0;
      pwm_s    <= 1'b0;
    end else begin
      pwm_meta <= pwm_in;
      pwm_s    <= pwm_meta;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic [1:0] pwm_hist;
  logic       pwm_filt;

  // The output follows pwm_s as soon as three consecutive samples agree:
  // the current pwm_s and its two previous values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_hist <= 2'b00;
      pwm_filt <= 1'b0;
    end else begin
      pwm_hist <= {pwm_hist[0], pwm_s};
      pwm_filt <= pwm_lvl;
    end
  end

  assign pwm_lvl = ((pwm_s == pwm_hist[0]) && (pwm_s == pwm_hist[1])) ? pwm_s : pwm_filt;
`else
  assign pwm_lvl = pwm_s;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pwm_d <= 1'b0;
    else        pwm_d <= pwm_lvl;
  end

  assign rise     = pwm_lvl & ~pwm_d;
  assign fall     = ~pwm_lvl & pwm_d;
  assign edge_hit = (state == MEAS_HIGH) ? fall : rise;
  assign cnt_inc  = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;  // saturating

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      hi_lat       <= '0;
      high_count   <= '0;
      period_count <= '0;
      meas_valid   <= 1'b0;
      timeout      <= 1'b0;
      stuck_level  <= 1'b0;
    end else begin
      // NOTE: meas_valid defaults low every cycle, so it is only a one-cycle
      // pulse where a branch below sets it.
      meas_valid <= 1'b0;
      if (!enable) begin
        state <= IDLE;
      end else if (state == IDLE) begin
        state <= WAIT_RISE;
        cnt   <= '0;
      end else if (edge_hit) begin
        // An expected edge takes priority over a coincident timeout.
        case (state)
          WAIT_RISE: begin
            cnt   <= 16'd1;
            state <= MEAS_HIGH;
          end
          MEAS_HIGH: begin
            hi_lat <= cnt;
            cnt    <= cnt_inc;
            state  <= MEAS_LOW;
          end
          MEAS_LOW: begin
            high_count   <= hi_lat;
            period_count <= cnt;
            meas_valid   <= 1'b1;
            timeout      <= 1'b0;
            cnt          <= 16'd1;
            state        <= MEAS_HIGH;
          end
          default: state <= IDLE;
        endcase
      end else if (cnt == TIMEOUT) begin
        high_count   <= pwm_lvl ? TIMEOUT : 16'd0;
        period_count <= TIMEOUT;
        meas_valid   <= 1'b1;
        timeout      <= 1'b1;
        stuck_level  <= pwm_lvl;
        cnt          <= '0;
        state        <= WAIT_RISE;
      end else begin
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// ---------------------------------------------------------------------------
// tb_pwm_capture
//
// Directed and random PWM streams are driven in whole clk cycles. Each time a
// waveform segment completes a measurement, the bench queues the expected
// result: high time, period, flags and the spacing from the previous result.
// A monitor compares every meas_valid pulse with the head of that queue.
// TIMEOUT is set to 100 so that stuck-level reports occur within a short run.
// ---------------------------------------------------------------------------
module tb_pwm_capture;

  localparam int TO_CYC = 100;

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic        pwm_in = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] high_count;
  logic [15:0] period_count;
  logic        meas_valid;
  logic        timeout;
  logic        stuck_level;

  pwm_capture #(.TIMEOUT(16'(TO_CYC))) dut (
    .clk          (clk),
    .reset        (reset),
    .pwm_in       (pwm_in),
    .enable       (enable),
    .high_count   (high_count),
    .period_count (period_count),
    .meas_valid   (meas_valid),
    .timeout      (timeout),
    .stuck_level  (stuck_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h;
    int p;
    int to;
    int st;
    int gap;  // required cycles since the previous pulse, 0 = unchecked
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fails  = 0;

  // Model of what the outputs should currently hold.
  int last_h  = 0;
  int last_p  = 0;
  int last_to = 0;
  int last_st = 0;

  // Period under way in the stimulus, reported at its closing rise.
  bit pend_valid = 1'b0;
  int pend_h     = 0;
  int pend_p     = 0;
  bit chain      = 1'b0;  // a result was expected at the rise opening pend

  task automatic check(input string tag, input int obs, input int expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push_meas(input int h, input int p, input int to, input int st, input int gap);
    exp_t e;
    e.h = h; e.p = p; e.to = to; e.st = st; e.gap = gap;
    exp_q.push_back(e);
    last_h = h; last_p = p; last_to = to; last_st = st;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic level, input int n);
    pwm_in = level;
    cycles(n);
  endtask

  // Called right before a rise is driven: that rise closes the pending period.
  task automatic start_period();
    if (pend_valid) begin
      push_meas(pend_h, pend_p, 0, last_st, chain ? pend_p : 0);
      chain = 1'b1;
    end else begin
      chain = 1'b0;
    end
    pend_valid = 1'b0;
  endtask

  task automatic period(input int h, input int l);
    start_period();
    drive(1'b1, h);
    drive(1'b0, l);
    pend_h     = h;
    pend_p     = h + l;
    pend_valid = 1'b1;
  endtask

  task automatic forget_period();
    pend_valid = 1'b0;
    chain      = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_high_count"},   int'(high_count),   0);
    check({tag, "_period_count"}, int'(period_count), 0);
    check({tag, "_meas_valid"},   int'(meas_valid),   0);
    check({tag, "_timeout"},      int'(timeout),      0);
    check({tag, "_stuck_level"},  int'(stuck_level),  0);
  endtask

  // Result monitor.
  int   cyc      = 0;
  int   last_cyc = 0;
  logic prev_mv  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      check("mv_not_back_to_back", int'(prev_mv), 0);
      check("mv_expected", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("mv_high_count",   int'(high_count),   mon_e.h);
        check("mv_period_count", int'(period_count), mon_e.p);
        check("mv_timeout",      int'(timeout),      mon_e.to);
        check("mv_stuck_level",  int'(stuck_level),  mon_e.st);
        if (mon_e.gap != 0) check("mv_spacing", cyc - last_cyc, mon_e.gap);
      end
      last_cyc = cyc;
    end
    prev_mv = meas_valid;
  end

  initial begin
    // Reset state.
    cycles(3);
    check_outputs_zero("reset");
    reset = 1'b1;
    cycles(2);

    // 5/11 stream, then random periods.
    enable = 1'b1;
    drive(1'b0, 5);
    repeat (4) period(5, 11);
    for (int i = 0; i < 8; i++) begin
      period(int'($urandom_range(40, 3)), int'($urandom_range(40, 3)));
    end
    repeat (2) period(5, 11);

    // Reset pulse in the low phase of a 5/11 period.
    start_period();
    drive(1'b1, 5);
    drive(1'b0, 4);
    check("pre_reset_queue_empty", exp_q.size(), 0);
    reset = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    forget_period();
    last_h = 0; last_p = 0; last_to = 0; last_st = 0;
    drive(1'b0, 6);
    repeat (3) period(5, 11);

    // enable dropped for 3 clk mid-period.
    start_period();
    drive(1'b1, 10);
    check("pre_disable_queue_empty", exp_q.size(), 0);
    enable = 1'b0;
    drive(1'b1, 3);
    check("disable_hold_high_count",   int'(high_count),   last_h);
    check("disable_hold_period_count", int'(period_count), last_p);
    check("disable_hold_timeout",      int'(timeout),      0);
    enable = 1'b1;
    forget_period();
    drive(1'b1, 2);
    drive(1'b0, 6);
    repeat (3) period(7, 9);
    start_period();
    drive(1'b1, 5);
    enable = 1'b0;
    forget_period();
    drive(1'b0, 10);
    check("idle_queue_empty",       exp_q.size(), 0);
    check("idle_hold_high_count",   int'(high_count),   7);
    check("idle_hold_period_count", int'(period_count), 16);

    // pwm stuck low: timeout 100 clk after WAIT_RISE entry, then every 101.
    push_meas(0, TO_CYC, 1, 0, 0);
    push_meas(0, TO_CYC, 1, 0, TO_CYC + 1);
    enable = 1'b1;
    cycles(250);
    check("stuck_low_queue_empty", exp_q.size(), 0);
    check("stuck_low_timeout",     int'(timeout), 1);

    // pwm stuck high, then an 8/8 period clears the timeout flag.
    push_meas(TO_CYC, TO_CYC, 1, 1, 0);
    drive(1'b1, 150);
    check("stuck_high_queue_empty", exp_q.size(), 0);
    check("stuck_high_level",       int'(stuck_level), 1);
    drive(1'b0, 8);
    forget_period();
    period(8, 8);
    start_period();

    // 1-clk glitch inside a 20-clk low phase.
    drive(1'b1, 6);
    drive(1'b0, 9);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    drive(1'b1, 1);
    drive(1'b0, 10);
    push_meas(6, 26, 0, 1, 26);
`else
    push_meas(6, 15, 0, 1, 15);
    drive(1'b1, 1);
    drive(1'b0, 10);
    push_meas(1, 11, 0, 1, 11);
`endif
    drive(1'b1, 5);
    enable = 1'b0;
    drive(1'b0, 10);
    check("final_queue_empty",       exp_q.size(), 0);
    check("final_hold_high_count",   int'(high_count),   last_h);
    check("final_hold_period_count", int'(period_count), last_p);
    check("final_timeout",           int'(timeout),      0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 16'hFFFF: cycle count without an expected edge before a stuck-level result is reported; legal range 4..16'hFFFF.
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port pwm_in  input  1  PWM waveform under measurement, asynchronous to clk.
REQ-005 SHALL provide port enable  input  1  measurement enable, synchronous to clk.
REQ-006 SHALL provide port high_count  output  16  clk cycles pwm_in was high in the last complete period.
REQ-007 SHALL provide port period_count  output  16  clk cycles of the last complete period, rise to rise.
REQ-008 SHALL provide port meas_valid  output  1  one-cycle pulse when high_count/period_count update.
REQ-009 SHALL provide port timeout  output  1  sticky flag set when a stuck level is reported.
REQ-010 SHALL provide port stuck_level  output  1  pwm_in level at the last timeout.

Function
REQ-011 SHALL synchronise pwm_in through two flops (pwm_s), then register pwm_s once more (pwm_d); rise = pwm_s & ~pwm_d, fall = ~pwm_s & pwm_d; pwm_in edge to rise/fall = 3 clk.
REQ-012 SHALL implement FSM states IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW.
REQ-013 IDLE: enable=1 -> WAIT_RISE; no counting; outputs hold.
REQ-014 WAIT_RISE: rise -> MEAS_HIGH with cnt<=1; any partial period before the first rise is discarded.
REQ-015 MEAS_HIGH: cnt<=cnt+1 each cycle; fall -> MEAS_LOW, hi_lat<=cnt (the pre-increment value).
REQ-016 MEAS_LOW: cnt<=cnt+1; rise -> high_count<=hi_lat, period_count<=cnt, meas_valid=1 next cycle, cnt<=1, stay in the measuring loop (MEAS_HIGH).
REQ-017 Counts: high H cycles, low L cycles -> high_count=H, period_count=H+L exactly; minimum resolvable H, L = 1 cycle each.
REQ-018 cnt SHALL saturate at 16'hFFFF, never wrap.
REQ-019 Timeout: in WAIT_RISE, MEAS_HIGH or MEAS_LOW, cnt==TIMEOUT with no qualifying edge this cycle -> high_count<=(pwm_s ? TIMEOUT : 0), period_count<=TIMEOUT, meas_valid pulse, timeout<=1, stuck_level<=pwm_s, cnt<=0, -> WAIT_RISE.
REQ-020 In WAIT_RISE, cnt SHALL count from 0 on entry.
REQ-021 Edge and timeout in the same cycle: the edge wins, no timeout.
REQ-022 timeout SHALL clear on the next rise-to-rise meas_valid; stuck_level holds.
REQ-023 enable=0 in any state -> IDLE next cycle; no meas_valid; high_count, period_count, timeout hold; re-enable restarts at WAIT_RISE.
REQ-024 meas_valid SHALL never be high two consecutive cycles.

Reset
REQ-025 reset low SHALL immediately force state IDLE; cnt, hi_lat, high_count, period_count = 0; meas_valid, timeout, stuck_level = 0; sync flops, pwm_d = 0.
REQ-026 Reset asserted mid-measurement SHALL discard the partial period; the first result after release requires a full rise-to-rise period.

Configuration
REQ-027 Macro PWM_CAPTURE_GLITCH_FILTER_EN defined: insert a filter after the synchroniser whose output changes only after 3 consecutive equal pwm_s samples; pulses shorter than 3 clk are ignored; edge-detect latency becomes 5 clk; minimum resolvable H, L = 3.
REQ-028 Macro undefined: no filter; behaviour exactly per REQ-011..REQ-024.

Verification
REQ-029 enable=1; pwm_in high 5 / low 11 repeated -> from the second period, meas_valid every 16 clk with high_count=5, period_count=16.
REQ-030 TIMEOUT=100; pwm_in held 0 -> 100 clk after WAIT_RISE entry: timeout=1, stuck_level=0, high_count=0, period_count=100; repeats every 101 clk.
REQ-031 TIMEOUT=100; pwm_in held 1 -> high_count=100, period_count=100, stuck_level=1; resume 8/8 PWM -> after the next full period, timeout=0, values 8/16.
REQ-032 Reset low for 1 clk during MEAS_LOW of a 5/11 stream -> all outputs 0 at once; first meas_valid only after one full subsequent period.
REQ-033 1-clk high glitch inside a 20-clk low phase: macro undefined -> spurious period reported; macro defined -> ignored, values unchanged.
REQ-034 Deassert enable mid-period for 3 clk -> no meas_valid, outputs hold; resumes from WAIT_RISE.
